// File: rtl/adc_echo_capture.sv
// adc_echo_capture: captures ADC samples while ACQ_EN is high and packs two 16-bit lanes per word
// into a FIFO, counting echo windows. Define ECHO_HEADER_EN to prefix each echo with a header word.
module adc_echo_capture #(
  parameter int DATABUS_WIDTH = 32,
  parameter int ADC_WIDTH     = 14,
  parameter int FIFO_DEPTH    = 256,
  localparam int ADDR_W       = $clog2(FIFO_DEPTH)
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     CLR,
  input  logic [DATABUS_WIDTH-1:0] NUM_ECHOES,
  input  logic                     ACQ_EN,
  input  logic [ADC_WIDTH-1:0]     ADC_DATA,
  input  logic                     FIFO_RD,
  output logic [DATABUS_WIDTH-1:0] FIFO_DOUT,
  output logic                     FIFO_EMPTY,
  output logic [ADDR_W:0]          FIFO_CNT,
  output logic                     OVERFLOW,
  output logic [DATABUS_WIDTH-1:0] ECHO_CNT,
  output logic                     ACQ_DONE
);
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FLUSH, S_DONE} state_t;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(FIFO_DEPTH);

  state_t                   state_q, state_d;
  logic [15:0]              lo_q, lo_d;
  logic                     lane_q, lane_d;
  logic                     wr_pend_q, wr_pend_d;
  logic [DATABUS_WIDTH-1:0] wr_word_q, wr_word_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]          cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     done_q, done_d;
  logic                     empty_q, empty_d;
  logic [DATABUS_WIDTH-1:0] dout_q, dout_d;
  logic [DATABUS_WIDTH-1:0] echo_q, echo_d;
  logic [DATABUS_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [15:0]              sample;
  logic [DATABUS_WIDTH-1:0] num_eff;
  logic [DATABUS_WIDTH-1:0] wr_data;
  logic                     capture, hdr_wr, flush_wr, wr_en, wr_acc, rd_acc;

  assign sample  = 16'(ADC_DATA);
  assign num_eff = (NUM_ECHOES == '0) ? DATABUS_WIDTH'(1) : NUM_ECHOES;

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    lane_d    = lane_q;
    wr_pend_d = 1'b0;
    wr_word_d = wr_word_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    done_d    = done_q;
    dout_d    = dout_q;
    echo_d    = echo_q;
    capture   = 1'b0;
    hdr_wr    = 1'b0;
    flush_wr  = 1'b0;
    wr_en     = 1'b0;
    wr_acc    = 1'b0;
    rd_acc    = 1'b0;
    wr_data   = wr_word_q;

    // CLR also drops any sample word still waiting to be written
    if (CLR) begin
      state_d  = S_IDLE;
      lo_d     = '0;
      lane_d   = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      done_d   = 1'b0;
      echo_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ACQ_EN) begin
            capture = 1'b1;
            state_d = S_CAPTURE;
`ifdef ECHO_HEADER_EN
            hdr_wr  = 1'b1;
`endif
          end
        end
        S_CAPTURE: begin
          if (ACQ_EN) capture = 1'b1;
          else        state_d = S_FLUSH;
        end
        S_FLUSH: begin
          flush_wr = lane_q;
          lane_d   = 1'b0;
          echo_d   = echo_q + DATABUS_WIDTH'(1);
          if (echo_d >= num_eff) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase

      // lane_q set means the low half of the next word is already held in lo_q
      if (capture) begin
        if (!lane_q) begin
          lo_d   = sample;
          lane_d = 1'b1;
        end else begin
          lane_d    = 1'b0;
          wr_pend_d = 1'b1;
          wr_word_d = {sample, lo_q};
        end
      end

      // The three write sources are mutually exclusive by construction of the state sequence
      wr_en = wr_pend_q | flush_wr | hdr_wr;
      if (hdr_wr)        wr_data = {16'hE0E0, echo_q[15:0]};
      else if (flush_wr) wr_data = {16'h0000, lo_q};

      rd_acc = FIFO_RD && (cnt_q != '0);
      wr_acc = wr_en && ((cnt_q < DEPTH) || rd_acc);
      if (wr_en && !wr_acc) ovf_d = 1'b1;

      if (rd_acc) begin
        dout_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      cnt_d = cnt_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    end

    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      lo_q      <= '0;
      lane_q    <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_word_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      empty_q   <= 1'b1;
      dout_q    <= '0;
      echo_q    <= '0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      lane_q    <= lane_d;
      wr_pend_q <= wr_pend_d;
      wr_word_q <= wr_word_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      empty_q   <= empty_d;
      dout_q    <= dout_d;
      echo_q    <= echo_d;
    end
  end

  // Storage array carries no reset; occupancy is tracked by the pointers
  always_ff @(posedge CLK) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  assign FIFO_DOUT  = dout_q;
  assign FIFO_EMPTY = empty_q;
  assign FIFO_CNT   = cnt_q;
  assign OVERFLOW   = ovf_q;
  assign ECHO_CNT   = echo_q;
  assign ACQ_DONE   = done_q;

endmodule

// File: tb/tb_adc_echo_capture.sv
// Self-checking bench for adc_echo_capture: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized windows/reads/clears.
module tb_adc_echo_capture;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CLR = 1'b0;
  logic [31:0] NUM_ECHOES = 32'd1;
  logic        ACQ_EN = 1'b0;
  logic [13:0] ADC_DATA = '0;
  logic        FIFO_RD = 1'b0;
  logic [31:0] FIFO_DOUT;
  logic        FIFO_EMPTY;
  logic [2:0]  FIFO_CNT;
  logic        OVERFLOW;
  logic [31:0] ECHO_CNT;
  logic        ACQ_DONE;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  adc_echo_capture #(.DATABUS_WIDTH(32), .ADC_WIDTH(14), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CLR(CLR), .NUM_ECHOES(NUM_ECHOES), .ACQ_EN(ACQ_EN),
    .ADC_DATA(ADC_DATA), .FIFO_RD(FIFO_RD), .FIFO_DOUT(FIFO_DOUT), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_CNT(FIFO_CNT), .OVERFLOW(OVERFLOW), .ECHO_CNT(ECHO_CNT), .ACQ_DONE(ACQ_DONE)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, samples of the current window as a queue
  logic [31:0] m_fifo[$];
  logic [15:0] m_smp[$];
  logic [31:0] m_dout = '0, m_echo = '0, m_wq = '0, mw;
  bit m_wq_v = 0, m_win = 0, m_flush = 0, m_done = 0, m_ovf = 0, mhave, mrd;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N || CLR) begin
      m_fifo.delete(); m_smp.delete();
      m_echo = '0; m_ovf = 0; m_done = 0; m_win = 0; m_flush = 0; m_wq_v = 0;
      if (!RESET_N) m_dout = '0;
    end else begin
      mrd = FIFO_RD && (m_fifo.size() > 0);
      mhave = 0; mw = '0;
      if (m_wq_v) begin mhave = 1; mw = m_wq; end
      if (m_flush && (m_smp.size() % 2 == 1)) begin
        mhave = 1; mw = {16'h0000, m_smp[m_smp.size()-1]};
      end
`ifdef ECHO_HEADER_EN
      if (!m_win && !m_flush && !m_done && ACQ_EN) begin
        mhave = 1; mw = {16'hE0E0, m_echo[15:0]};
      end
`endif
      m_wq_v = 0;
      if (m_flush) begin
        m_flush = 0; m_smp.delete(); m_echo = m_echo + 32'd1;
        if (m_echo >= ((NUM_ECHOES == 32'd0) ? 32'd1 : NUM_ECHOES)) m_done = 1;
      end else if (!m_done) begin
        if (ACQ_EN) begin
          m_win = 1;
          m_smp.push_back(16'(ADC_DATA));
          if (m_smp.size() % 2 == 0) begin
            m_wq = {m_smp[m_smp.size()-1], m_smp[m_smp.size()-2]}; m_wq_v = 1;
          end
        end else if (m_win) begin
          m_win = 0; m_flush = 1;
        end
      end
      if (mrd) m_dout = m_fifo.pop_front();
      if (mhave) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(mw);
        else m_ovf = 1;
      end
    end
  end

  always @(negedge CLK) begin
    chk("dout",  FIFO_DOUT, m_dout);
    chk("empty", 32'(FIFO_EMPTY), 32'(m_fifo.size() == 0));
    chk("cnt",   32'(FIFO_CNT), 32'(m_fifo.size()));
    chk("ovf",   32'(OVERFLOW), 32'(m_ovf));
    chk("echo",  ECHO_CNT, m_echo);
    chk("done",  32'(ACQ_DONE), 32'(m_done));
  end

  task automatic cyc(input logic clr, input logic en, input logic [13:0] d, input logic rd);
    CLR = clr; ACQ_EN = en; ADC_DATA = d; FIFO_RD = rd;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 14'h0, 1'b0);
  endtask

  logic [31:0] exp4 [4];
  bit          en_r;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_empty", 32'(FIFO_EMPTY), 32'd1);
    chk("rst_cnt",   32'(FIFO_CNT), 32'd0);
    chk("rst_dout",  FIFO_DOUT, 32'd0);
    RESET_N = 1'b1;

`ifndef ECHO_HEADER_EN
    // Two echoes of four samples each
    NUM_ECHOES = 32'd2;
    cyc(1'b1, 1'b0, 14'h0, 1'b0);
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 14'(i), 1'b0);
    idle(3);
    chk("t1_echo_mid", ECHO_CNT, 32'd1);
    chk("t1_done_mid", 32'(ACQ_DONE), 32'd0);
    for (int i = 5; i <= 8; i++) cyc(1'b0, 1'b1, 14'(i), 1'b0);
    idle(3);
    chk("t1_echo", ECHO_CNT, 32'd2);
    chk("t1_done", 32'(ACQ_DONE), 32'd1);
    chk("t1_cnt",  32'(FIFO_CNT), 32'd4);
    exp4 = '{32'h00020001, 32'h00040003, 32'h00060005, 32'h00080007};
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 14'h0, 1'b1);
      chk("t1_word", FIFO_DOUT, exp4[k]);
    end

    // Odd sample count, done timing
    NUM_ECHOES = 32'd1;
    cyc(1'b1, 1'b0, 14'h0, 1'b0);
    cyc(1'b0, 1'b1, 14'hA, 1'b0);
    cyc(1'b0, 1'b1, 14'hB, 1'b0);
    cyc(1'b0, 1'b1, 14'hC, 1'b0);
    cyc(1'b0, 1'b0, 14'h0, 1'b0);
    chk("t2_done_pre", 32'(ACQ_DONE), 32'd0);
    cyc(1'b0, 1'b0, 14'h0, 1'b0);
    chk("t2_done", 32'(ACQ_DONE), 32'd1);
    chk("t2_cnt",  32'(FIFO_CNT), 32'd2);
    cyc(1'b0, 1'b0, 14'h0, 1'b1);
    chk("t2_w0", FIFO_DOUT, 32'h000B000A);
    cyc(1'b0, 1'b0, 14'h0, 1'b1);
    chk("t2_w1", FIFO_DOUT, 32'h0000000C);

    // Overflow: 12 samples into a 4-deep FIFO
    cyc(1'b1, 1'b0, 14'h0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 14'(16 + i), 1'b0);
    idle(3);
    chk("t3_cnt", 32'(FIFO_CNT), 32'd4);
    chk("t3_ovf", 32'(OVERFLOW), 32'd1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 14'h0, 1'b1);
      chk("t3_word", FIFO_DOUT, {16'(17 + 2*k), 16'(16 + 2*k)});
    end
    cyc(1'b0, 1'b0, 14'h0, 1'b1);
    chk("t3_rd_empty_hold", FIFO_DOUT, 32'h0017_0016);
    chk("t3_empty", 32'(FIFO_EMPTY), 32'd1);

    // Read and write together while full
    cyc(1'b1, 1'b0, 14'h0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 14'(32 + i), 1'b0);
    chk("t4_cnt_full", 32'(FIFO_CNT), 32'd4);
    cyc(1'b0, 1'b0, 14'h0, 1'b1);
    chk("t4_cnt", 32'(FIFO_CNT), 32'd4);
    chk("t4_ovf", 32'(OVERFLOW), 32'd0);
    chk("t4_dout", FIFO_DOUT, 32'h0021_0020);
    idle(2);

    // CLR on the third sample of a window
    NUM_ECHOES = 32'd3;
    cyc(1'b1, 1'b0, 14'h0, 1'b0);
    cyc(1'b0, 1'b1, 14'h1, 1'b0);
    cyc(1'b0, 1'b1, 14'h2, 1'b0);
    idle(3);
    chk("t5_echo_pre", ECHO_CNT, 32'd1);
    cyc(1'b0, 1'b1, 14'h3, 1'b0);
    cyc(1'b0, 1'b1, 14'h4, 1'b0);
    cyc(1'b1, 1'b1, 14'h5, 1'b0);
    chk("t5_empty", 32'(FIFO_EMPTY), 32'd1);
    chk("t5_echo",  ECHO_CNT, 32'd0);
    idle(3);
    chk("t5_empty_after", 32'(FIFO_EMPTY), 32'd1);

    // Asynchronous reset mid-capture
    cyc(1'b0, 1'b1, 14'h6, 1'b0);
    cyc(1'b0, 1'b1, 14'h7, 1'b0);
    idle(3);
    cyc(1'b0, 1'b0, 14'h0, 1'b1);
    chk("t5_dout_pre", FIFO_DOUT, 32'h0007_0006);
    cyc(1'b0, 1'b1, 14'h8, 1'b0);
    cyc(1'b0, 1'b1, 14'h9, 1'b0);
    cyc(1'b0, 1'b1, 14'hA, 1'b0);
    ACQ_EN = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_async_dout",  FIFO_DOUT, 32'd0);
    chk("rst_async_empty", 32'(FIFO_EMPTY), 32'd1);
    chk("rst_async_cnt",   32'(FIFO_CNT), 32'd0);
    chk("rst_async_ovf",   32'(OVERFLOW), 32'd0);
    chk("rst_async_echo",  ECHO_CNT, 32'd0);
    chk("rst_async_done",  32'(ACQ_DONE), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
`else
    // Header words ahead of each echo; ACQ_EN in DONE writes nothing
    NUM_ECHOES = 32'd2;
    cyc(1'b1, 1'b0, 14'h0, 1'b0);
    cyc(1'b0, 1'b1, 14'h1, 1'b0);
    cyc(1'b0, 1'b1, 14'h2, 1'b0);
    idle(3);
    cyc(1'b0, 1'b1, 14'h3, 1'b0);
    cyc(1'b0, 1'b1, 14'h4, 1'b0);
    idle(3);
    cyc(1'b0, 1'b1, 14'h9, 1'b0);
    idle(2);
    chk("t6_cnt", 32'(FIFO_CNT), 32'd4);
    chk("t6_ovf", 32'(OVERFLOW), 32'd0);
    chk("t6_done", 32'(ACQ_DONE), 32'd1);
    exp4 = '{32'hE0E00000, 32'h00020001, 32'hE0E00001, 32'h00040003};
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 14'h0, 1'b1);
      chk("t6_word", FIFO_DOUT, exp4[k]);
    end
`endif

    // Randomized windows, reads and occasional clears
    en_r = 0;
    for (int r = 0; r < 40; r++) begin
      NUM_ECHOES = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 4));
      cyc(1'b1, 1'($urandom_range(0, 1)), 14'($urandom), 1'b0);
      for (int c = 0; c < 120; c++) begin
        if ($urandom_range(0, 4) == 0) en_r = ~en_r;
        cyc(1'($urandom_range(0, 150) == 0), en_r, 14'($urandom), 1'($urandom_range(0, 2) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
